// File: rtl/ser_frame_tx.sv
// rtl/ser_frame_tx.sv - single-wire framed serial transmitter (start, addr, len, payload, gap)
module ser_frame_tx #(
    parameter int ADDR_W     = 2,
    parameter int LEN_W      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [ADDR_W-1:0]       tx_addr,
    input  logic [LEN_W-1:0]        tx_len,
    input  logic [(2**LEN_W)-2:0]   tx_data,
    output logic                    ser_out,
    output logic                    busy,
    output logic                    done
);

    localparam int DATA_W = (2**LEN_W) - 1;
    localparam int CNT_W  = LEN_W + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
    localparam logic [LEN_W-1:0] DATA_TOP  = LEN_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_GAP
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_sh;
    logic [LEN_W-1:0]   len_sh;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  data_sh;
    // bits of the current field already placed on the line; one bit wider
    // than the length field so a 15-bit payload count never wraps
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    assign tx_ready = (state == S_IDLE);

    // Frame sequencer: each edge decides the next state and the bit it drives,
    // so ser_out/busy/done are all registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            ser_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            addr_sh <= '0;
            len_sh  <= '0;
            len_q   <= '0;
            data_sh <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    ser_out <= 1'b1;
                    busy    <= 1'b0;
                    if (tx_valid) begin
                        addr_sh <= tx_addr;
                        len_sh  <= tx_len;
                        len_q   <= tx_len;
                        // left-align the valid field so its MSB sits at the top
                        data_sh <= tx_data << (DATA_TOP - tx_len);
                        ser_out <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                end

                S_START: begin
                    ser_out <= addr_sh[ADDR_W-1];
                    addr_sh <= addr_sh << 1;
                    bit_cnt <= CNT_ONE;
                    state   <= S_ADDR;
                end

                S_ADDR: begin
                    if (bit_cnt < ADDR_LAST) begin
                        ser_out <= addr_sh[ADDR_W-1];
                        addr_sh <= addr_sh << 1;
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end else begin
                        ser_out <= len_sh[LEN_W-1];
                        len_sh  <= len_sh << 1;
                        bit_cnt <= CNT_ONE;
                        state   <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (bit_cnt < LEN_LAST) begin
                        ser_out <= len_sh[LEN_W-1];
                        len_sh  <= len_sh << 1;
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end else if (len_q == '0) begin
                        ser_out <= 1'b1;
                        done    <= 1'b1;
                        gap_cnt <= GAP_ONE;
                        state   <= S_GAP;
                    end else begin
                        ser_out <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        bit_cnt <= CNT_ONE;
                        state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bit_cnt < {1'b0, len_q}) begin
                        ser_out <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end else begin
                        ser_out <= 1'b1;
                        done    <= 1'b1;
                        gap_cnt <= GAP_ONE;
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    ser_out <= 1'b1;
                    if (gap_cnt < GAP_LAST) begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    ser_out <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_frame_tx.sv
// tb/tb_ser_frame_tx.sv - randomized and directed checks of ser_frame_tx against a frame-list model
module tb_ser_frame_tx;

    localparam int ADDR_W     = 2;
    localparam int LEN_W      = 4;
    localparam int GAP_CYCLES = 1;

    logic        clk;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  tx_addr;
    logic [3:0]  tx_len;
    logic [14:0] tx_data;
    logic        ser_out;
    logic        busy;
    logic        done;

    ser_frame_tx #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_addr  (tx_addr),
        .tx_len   (tx_len),
        .tx_data  (tx_data),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic ser;
        logic bsy;
        logic dn;
        logic rdy;
    } obs_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_obs;
    obs_t pend_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    function automatic obs_t mk(input logic s, input logic b, input logic d, input logic r);
        obs_t o;
        o.ser = s;
        o.bsy = b;
        o.dn  = d;
        o.rdy = r;
        return o;
    endfunction

    // Whole frame as a list of per-cycle line observations, straight from the frame format.
    function automatic void build_frame(input logic [1:0] a, input logic [3:0] l, input logic [14:0] d);
        pend_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = ADDR_W - 1; i >= 0; i--) pend_q.push_back(mk(a[i], 1'b1, 1'b0, 1'b0));
        for (int i = LEN_W - 1; i >= 0; i--)  pend_q.push_back(mk(l[i], 1'b1, 1'b0, 1'b0));
        for (int i = int'(l) - 1; i >= 0; i--) pend_q.push_back(mk(d[i], 1'b1, 1'b0, 1'b0));
        for (int g = 0; g < GAP_CYCLES; g++) pend_q.push_back(mk(1'b1, 1'b1, (g == 0), 1'b0));
    endfunction

    // One clock: advance the model at the edge, compare all outputs mid-cycle.
    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            pend_q.delete();
            exp_obs = mk(1'b1, 1'b0, 1'b0, 1'b1);
        end else begin
            if (exp_obs.rdy && tx_valid) build_frame(tx_addr, tx_len, tx_data);
            if (pend_q.size() > 0) exp_obs = pend_q.pop_front();
            else exp_obs = mk(1'b1, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        check("ser_out",  32'(ser_out),  32'(exp_obs.ser));
        check("busy",     32'(busy),     32'(exp_obs.bsy));
        check("done",     32'(done),     32'(exp_obs.dn));
        check("tx_ready", 32'(tx_ready), 32'(exp_obs.rdy));
    endtask

    // Hold a request until it is taken; returns at mid-cycle of the start bit.
    task automatic send(input logic [1:0] a, input logic [3:0] l, input logic [14:0] d,
                        input bit keep, output int ncyc);
        bit acc;
        bit was_ready;
        acc      = 1'b0;
        ncyc     = 0;
        tx_addr  = a;
        tx_len   = l;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            was_ready = exp_obs.rdy;
            cycle();
            ncyc++;
            if (was_ready) acc = 1'b1;
        end
        if (!keep) tx_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    logic [12:0] cap13;
    logic [12:0] dn13;
    logic [7:0]  cap8;
    logic [7:0]  dn8;
    int          nc;

    initial begin
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_addr  = '0;
        tx_len   = '0;
        tx_data  = '0;
        exp_obs  = mk(1'b1, 1'b0, 1'b0, 1'b1);

        cycle();
        cycle();
        check("reset_ser",   32'(ser_out),  32'd1);
        check("reset_ready", 32'(tx_ready), 32'd1);
        rst = 1'b1;
        cycle();

        // basic frame: addr 11, len 5, payload 10110
        send(2'b11, 4'd5, 15'h0016, 1'b0, nc);
        for (int i = 0; i < 13; i++) begin
            cap13[12 - i] = ser_out;
            dn13[12 - i]  = done;
            if (i < 12) cycle();
        end
        check("basic_bits", 32'(cap13), 32'(13'b0110101101101));
        check("basic_done", 32'(dn13),  32'(13'b0000000000001));
        cycle();
        check("basic_ready_k14", 32'(tx_ready), 32'd1);
        repeat (3) cycle();

        // zero length
        send(2'b01, 4'd0, 15'h7FFF, 1'b0, nc);
        for (int i = 0; i < 8; i++) begin
            cap8[7 - i] = ser_out;
            dn8[7 - i]  = done;
            if (i < 7) cycle();
        end
        check("zero_bits", 32'(cap8), 32'(8'b00100001));
        check("zero_done", 32'(dn8),  32'(8'b00000001));
        repeat (3) cycle();

        // max length, then short frame with upper bits set
        send(2'b10, 4'd15, 15'h5555, 1'b0, nc);
        repeat (25) cycle();
        send(2'b10, 4'd3, 15'h7FF8, 1'b0, nc);
        repeat (14) cycle();

        // new request raised during DATA of a running frame
        send(2'b00, 4'd10, 15'h2D3, 1'b0, nc);
        repeat (8) cycle();
        send(2'b11, 4'd2, 15'h0002, 1'b0, nc);
        repeat (12) cycle();

        // reset during the length field, then a fresh frame
        send(2'b10, 4'd6, 15'h002A, 1'b0, nc);
        repeat (3) cycle();
        rst = 1'b0;
        tx_valid = 1'b1;
        cycle();
        check("abort_ser",   32'(ser_out),  32'd1);
        check("abort_busy",  32'(busy),     32'd0);
        check("abort_done",  32'(done),     32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        tx_valid = 1'b0;
        rst = 1'b1;
        repeat (15) cycle();
        send(2'b01, 4'd4, 15'h0009, 1'b0, nc);
        repeat (14) cycle();

        // back-to-back with tx_valid held high
        send(2'b01, 4'd3, 15'h0005, 1'b1, nc);
        send(2'b10, 4'd2, 15'h0001, 1'b1, nc);
        check("b2b_spacing", 32'(nc), 32'(3 + 9 + GAP_CYCLES - 1));
        check("b2b_start",   32'(ser_out), 32'd0);
        tx_valid = 1'b0;
        repeat (14) cycle();

        // randomized traffic, including inputs changing while busy and rare resets
        for (int n = 0; n < 2000; n++) begin
            rst      = ($urandom_range(0, 149) != 0);
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_addr  = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       tx_len = 4'd0;
                1:       tx_len = 4'd15;
                default: tx_len = 4'($urandom);
            endcase
            tx_data = 15'($urandom);
            cycle();
        end
        rst      = 1'b1;
        tx_valid = 1'b0;
        repeat (30) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ser_frame_tx.md
Name: ser_frame_tx

Overview:
- Serial frame transmitter. Produces the single-wire framed bit stream that the serial port-router top (SerIn input) consumes.
- Frame format:
  - line idles high
  - start bit 0
  - 2-bit channel address, MSB first
  - 4-bit length N, MSB first
  - N payload bits, MSB of the valid field first
  - line returns high
- Loaded through a valid/ready handshake from a local controller. Emits one bit per clock.

Parameters:
- ADDR_W, 2: channel address width in bits.
- LEN_W, 4: length field width. Maximum payload is 2**LEN_W-1 = 15 bits.
- GAP_CYCLES, 1: number of forced idle-high cycles after each frame. Minimum legal value is 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low. Sampled on clk rising edge.
- tx_valid  in  1  request to send a frame.
- tx_ready  out  1  high when a frame can be accepted (state IDLE).
- tx_addr  in  ADDR_W  destination channel.
- tx_len  in  LEN_W  payload bit count N, 0..15.
- tx_data  in  2**LEN_W-1  payload. Only bits [N-1:0] are sent; bits [14:N] are ignored.
- ser_out  out  1  serial line, registered.
- busy  out  1  high from the start bit through the last gap cycle.
- done  out  1  one-cycle pulse after the last frame bit.

Behaviour:
- Reset (rst=0 at an edge):
  - state goes to IDLE.
  - Next-cycle values: ser_out=1, busy=0, done=0, tx_ready=1.
  - Applies at any point, including mid-frame. The frame is abandoned and the line goes high the cycle after rst is sampled.
  - tx_valid is ignored while rst=0.
- tx_ready is decoded as (state==IDLE).
- Accept:
  - At edge k with tx_valid && tx_ready, latch tx_addr, tx_len and tx_data into internal shift/count registers.
  - Input changes after k have no effect on the frame.
- States: IDLE -> START (1 cycle) -> ADDR (ADDR_W cycles) -> LEN (LEN_W cycles) -> DATA (N cycles, skipped if N=0) -> GAP (GAP_CYCLES cycles) -> IDLE.
- Cycle timing relative to acceptance edge k:
  - k+1: ser_out=0 (start bit); busy=1, tx_ready=0.
  - k+2 .. k+1+ADDR_W: address bits, MSB first.
  - next LEN_W cycles: length bits, MSB first.
  - next N cycles: tx_data[N-1] down to tx_data[0].
  - With defaults, the last data bit is at k+7+N.
  - First GAP cycle (k+8+N with defaults): ser_out=1, done=1 for exactly one cycle, busy=1.
  - Last GAP cycle is followed by IDLE: busy=0, tx_ready=1.
  - Earliest next start bit is 2 cycles after the IDLE cycle's accepting edge.
- N=0: frame is start + addr + len only (7 bits). done at k+8.
- ser_out is high in IDLE and GAP. It never glitches low outside START and the 0-bits of a frame.
- tx_valid while busy is ignored, not queued. The controller must hold tx_valid until it sees tx_ready.
- tx_valid held high continuously: frames are sent back-to-back, separated by GAP_CYCLES idle cycles plus the IDLE accept cycle.
- Counters:
  - bit counter is LEN_W+1 bits wide, so no wrap at N=15.
  - gap counter is sized for GAP_CYCLES.

Test Plan:
- Basic frame: reset 2 cycles, then tx_valid with addr=2'b11, len=4'd5, data=15'h0016 (field 10110).
  - ser_out from k+1 must be 0,1,1,0,1,0,1,1,0,1,1,0, then 1.
  - done=1 only at k+13.
  - tx_ready=1 again at k+14.
- Zero length: addr=2'b01, len=0, data=15'h7FFF.
  - ser_out = 0,0,1,0,0,0,0, then 1.
  - done at k+8.
  - No data bits emitted.
- Maximum length with ignored-bit check: addr=2'b10, len=15, data=15'h5555, then repeat with len=3, data=15'h7FF8.
  - First frame: 15 alternating bits 1,0,1,...,1 after the length field 1111; done at k+23.
  - Second frame: payload 0,0,0 (upper bits ignored).
- Busy-time request: assert tx_valid with new values during the DATA state of a frame.
  - Current frame bits unchanged.
  - New frame starts only after IDLE is reached and tx_ready is seen.
- Reset mid-frame: drive rst=0 during the LEN field.
  - Next cycle ser_out=1, busy=0, done=0, tx_ready=1.
  - No done pulse for the aborted frame.
  - After rst=1, a fresh frame is transmitted correctly.
- Back-to-back: tx_valid held high with two queued controller frames.
  - Exactly GAP_CYCLES+1 high cycles between the last bit of frame 1 and the start bit of frame 2.
  - One done pulse per frame.
